img_marker_scan: RTL and testbench
==================================

Name: img_marker_scan

Overview:
- Raster-scans the 320x240 3-bit image SRAM once per request.
- Accumulates the sum of all pixels and locates the start marker (first PRE_S→START_CODE transition) and end marker (first PRE_E→END_CODE transition).
- Sits directly upstream of the top-level LCD formatter, which displays the sum and the coordinates as hex.
- Replaces the divide-based coordinate recovery with row/column counters.

Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- ADDR_W, 17, SRAM address width
- PIX_W, 3, pixel width
- SUM_W, 20, accumulator width (IMG_W*IMG_H*(2^PIX_W-1) fits)
- PRE_S, 4, pixel value that must precede a start marker
- START_CODE, 0, start marker value
- PRE_E, 0, pixel value that must precede an end marker
- END_CODE, 4, end marker value

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  scan request pulse; sampled only in IDLE
- sram_en  out  1  SRAM read enable
- sram_addr  out  ADDR_W  SRAM read address
- pix_data  in  PIX_W  SRAM read data, valid one cycle after address
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when results are final
- sum  out  SUM_W  sum of all pixels
- start_found  out  1  start marker located
- start_x  out  12  start column, 0-based
- start_y  out  12  start row, 0-based
- end_found  out  1  end marker located
- end_x  out  12  end column, 0-based
- end_y  out  12  end row, 0-based

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE. busy, done, sram_en, sram_addr, sum, flags and coordinates all reset to 0. Reset mid-scan aborts immediately; no done pulse is issued.
- FSM states: IDLE, SCAN, DRAIN, FIN.
- IDLE: on start=1, clear sum, flags, coordinates and prev-pixel-valid; set busy; go to SCAN with sram_addr=0, col=0, row=0.
- SCAN:
  - sram_en=1; sram_addr advances by 1 each cycle.
  - col counts 0..IMG_W-1, then wraps to 0 and increments row. No division is used.
  - The cycle that issues address IMG_W*IMG_H-1 moves to DRAIN.
- Data path, 1-cycle SRAM latency:
  - The col/row of the issued address are registered as dcol/drow and paired with pix_data on the next cycle.
  - A pixel valid flag (pv) is high for exactly IMG_W*IMG_H cycles, from the cycle after SCAN entry through DRAIN.
  - While pv=1: sum += pix_data, zero-extended.
- Transitions:
  - prev holds the previous valid pixel. prev is invalid for pixel 0, so pixel 0 can never be a marker.
  - Transitions span row boundaries (raster order).
  - Start: if !start_found, prev valid, prev==PRE_S and pix==START_CODE, latch start_x=dcol, start_y=drow, start_found=1.
  - End: if !end_found, prev valid, prev==PRE_E and pix==END_CODE, latch end_x=dcol, end_y=drow, end_found=1.
  - Both may latch in the same cycle. Later matches are ignored.
- DRAIN: sram_en=0; consumes the last pixel. Next state FIN.
- FIN: done=1 for one cycle, busy=0 on the following cycle; go to IDLE.
- Latency: start accepted at cycle 0 → done asserted at cycle IMG_W*IMG_H+2.
- Outputs hold their values until the next accepted start.
- A marker not found leaves its flag at 0 and its coordinates at 0.
- start while busy is ignored; no queueing.
- Coordinate outputs are zero-extended to 12 bits.

Decomposition:
- Shared package holds:
  - image geometry constants IMG_W, IMG_H
  - marker code constants
  - the FSM state enum
- One natural sub-module: raster_counter. It generates addr/col/row with wrap and a last flag, and the top-level SRAM-scan states can reuse it.
- Accumulate/compare logic stays inline.

Test Plan:
- All-zero image, start pulse → done exactly 76802 cycles later; sum=0; start_found=0; end_found=0.
- Pixel 5 = value 4, pixel 6 = 0, rest 7 → start_found=1, (start_x,start_y)=(6,0); end_found=0; sum=7*76798+4.
- Pixel 319 = 0, pixel 320 = 4, rest 7 (row-crossing end) → end=(0,1); start_found=0.
- Image with two 4→0 transitions, at addresses 1000 and 2000 → start=(40,3) only (first match wins).
- Assert reset_n=0 at SCAN cycle 500 → all outputs 0 asynchronously, no done. Fresh start after release completes normally.
- Second start pulse while busy is ignored → single done. Results are identical to a single-request run.

Source files
------------

// File: rtl/img_marker_scan_pkg.sv
// Shared definitions for the image marker scanner.
// Holds the default image geometry, bus widths, the marker codes that
// define a start/end transition, and the scanner FSM state type.
package img_marker_scan_pkg;

  localparam int IMG_W   = 320;
  localparam int IMG_H   = 240;
  localparam int ADDR_W  = 17;
  localparam int PIX_W   = 3;
  localparam int SUM_W   = 20;
  localparam int COORD_W = 12;

  // A start marker is a PRE_S pixel immediately followed by START_CODE,
  // an end marker is PRE_E followed by END_CODE, both in raster order.
  localparam logic [PIX_W-1:0] PRE_S      = 3'd4;
  localparam logic [PIX_W-1:0] START_CODE = 3'd0;
  localparam logic [PIX_W-1:0] PRE_E      = 3'd0;
  localparam logic [PIX_W-1:0] END_CODE   = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/img_marker_scan_raster_counter.sv
// Raster address generator.
// Produces a linear SRAM address together with the matching column and
// row, so pixel coordinates never need a divide.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   clear         return to address 0 / column 0 / row 0
//   advance       step to the next pixel in raster order
//   addr          linear address of the current pixel
//   col, row      coordinates of the current pixel
//   last          current pixel is the final one of the image
module img_marker_scan_raster_counter #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int COL_W  = 9,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

  assign last = (addr == LAST_ADDR);

  // Stepping past the last pixel wraps the whole position back to the origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (clear || (advance && last)) begin
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (advance) begin
      addr <= addr + 1'b1;
      if (col == LAST_COL) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/img_marker_scan.sv
// Image marker scanner.
// On each accepted start, reads every pixel of the image SRAM once in
// raster order, sums all pixel values and records the coordinates of the
// first start-marker and first end-marker transitions.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start                  scan request, honoured only when idle
//   sram_en, sram_addr     SRAM read request
//   pix_data               SRAM read data, one cycle after the address
//   busy                   scan in progress (through the done cycle)
//   done                   one-cycle pulse, results final
//   sum                    sum of all pixels
//   start_found/x/y        first start marker and its column/row
//   end_found/x/y          first end marker and its column/row
module img_marker_scan #(
  parameter int IMG_W = img_marker_scan_pkg::IMG_W,
  parameter int IMG_H = img_marker_scan_pkg::IMG_H
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    start,
  output logic                                    sram_en,
  output logic [img_marker_scan_pkg::ADDR_W-1:0]  sram_addr,
  input  logic [img_marker_scan_pkg::PIX_W-1:0]   pix_data,
  output logic                                    busy,
  output logic                                    done,
  output logic [img_marker_scan_pkg::SUM_W-1:0]   sum,
  output logic                                    start_found,
  output logic [img_marker_scan_pkg::COORD_W-1:0] start_x,
  output logic [img_marker_scan_pkg::COORD_W-1:0] start_y,
  output logic                                    end_found,
  output logic [img_marker_scan_pkg::COORD_W-1:0] end_x,
  output logic [img_marker_scan_pkg::COORD_W-1:0] end_y
);

  import img_marker_scan_pkg::*;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_t           state;
  logic             accept;
  logic             cnt_last;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] dcol;
  logic [ROW_W-1:0] drow;
  logic             pv;
  logic [PIX_W-1:0] prev_pix;
  logic             prev_valid;
  logic             hit_start;
  logic             hit_end;

  // busy is still high during the done cycle, so a start arriving right
  // after done is dropped rather than accepted.
  assign accept = (state == IDLE) && start && !busy;

  assign hit_start = !start_found && prev_valid &&
                     (prev_pix == PRE_S) && (pix_data == START_CODE);
  assign hit_end   = !end_found && prev_valid &&
                     (prev_pix == PRE_E) && (pix_data == END_CODE);

  img_marker_scan_raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .advance (state == SCAN),
    .addr    (sram_addr),
    .col     (col),
    .row     (row),
    .last    (cnt_last)
  );

  // The position of each issued address is delayed one cycle (dcol/drow,
  // pv) so that it lines up with the pixel the SRAM returns for it.
  // prev_valid is cleared on acceptance so the first pixel of a scan can
  // never pair with the last pixel of the previous scan.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      sram_en     <= 1'b0;
      pv          <= 1'b0;
      dcol        <= '0;
      drow        <= '0;
      prev_pix    <= '0;
      prev_valid  <= 1'b0;
      sum         <= '0;
      start_found <= 1'b0;
      start_x     <= '0;
      start_y     <= '0;
      end_found   <= 1'b0;
      end_x       <= '0;
      end_y       <= '0;
    end else begin
      done <= 1'b0;
      pv   <= (state == SCAN);

      if (state == SCAN) begin
        dcol <= col;
        drow <= row;
      end

      if (pv) begin
        sum        <= sum + SUM_W'(pix_data);
        prev_pix   <= pix_data;
        prev_valid <= 1'b1;
        if (hit_start) begin
          start_found <= 1'b1;
          start_x     <= COORD_W'(dcol);
          start_y     <= COORD_W'(drow);
        end
        if (hit_end) begin
          end_found <= 1'b1;
          end_x     <= COORD_W'(dcol);
          end_y     <= COORD_W'(drow);
        end
      end

      case (state)
        IDLE: begin
          if (accept) begin
            busy        <= 1'b1;
            sram_en     <= 1'b1;
            sum         <= '0;
            prev_valid  <= 1'b0;
            start_found <= 1'b0;
            start_x     <= '0;
            start_y     <= '0;
            end_found   <= 1'b0;
            end_x       <= '0;
            end_y       <= '0;
            state       <= SCAN;
          end else begin
            busy <= 1'b0;
          end
        end
        SCAN: begin
          if (cnt_last) begin
            sram_en <= 1'b0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          state <= FIN;
        end
        FIN: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_marker_scan.sv
// Testbench for img_marker_scan.
// A full-size instance checks the end-to-end latency on a blank image; a
// 320x7 instance (same row length, so the same coordinates) runs the
// marker, boundary, ignored-start and reset-abort scenarios quickly.
// Expected results come from a raster-order model over the image array.
module tb_img_marker_scan;

  import img_marker_scan_pkg::*;

  localparam int SW = 320;
  localparam int SH = 7;
  localparam int NB = IMG_W * IMG_H;
  localparam int NS = SW * SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start_big, start_small;

  logic              b_en, b_busy, b_done, b_sf, b_ef;
  logic [ADDR_W-1:0] b_addr;
  logic [PIX_W-1:0]  b_pix;
  logic [SUM_W-1:0]  b_sum;
  logic [11:0]       b_sx, b_sy, b_ex, b_ey;

  logic              s_en, s_busy, s_done, s_sf, s_ef;
  logic [ADDR_W-1:0] s_addr;
  logic [PIX_W-1:0]  s_pix;
  logic [SUM_W-1:0]  s_sum;
  logic [11:0]       s_sx, s_sy, s_ex, s_ey;

  logic [PIX_W-1:0] mem [0:NB-1];

  int edge_cnt = 0;
  int t0 = 0;
  int done_k = -1;
  bit mon_big = 1'b0;
  bit mon_small = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  int exp_sum;
  bit exp_sf, exp_ef;
  int exp_sx, exp_sy, exp_ex, exp_ey;

  img_marker_scan u_big (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start_big),
    .sram_en     (b_en),
    .sram_addr   (b_addr),
    .pix_data    (b_pix),
    .busy        (b_busy),
    .done        (b_done),
    .sum         (b_sum),
    .start_found (b_sf),
    .start_x     (b_sx),
    .start_y     (b_sy),
    .end_found   (b_ef),
    .end_x       (b_ex),
    .end_y       (b_ey)
  );

  img_marker_scan #(.IMG_W(SW), .IMG_H(SH)) u_small (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start_small),
    .sram_en     (s_en),
    .sram_addr   (s_addr),
    .pix_data    (s_pix),
    .busy        (s_busy),
    .done        (s_done),
    .sum         (s_sum),
    .start_found (s_sf),
    .start_x     (s_sx),
    .start_y     (s_sy),
    .end_found   (s_ef),
    .end_x       (s_ex),
    .end_y       (s_ey)
  );

  // Synchronous-read SRAM models sharing one image array.
  always @(posedge clk) begin
    if (b_en) b_pix <= mem[b_addr];
    if (s_en) s_pix <= mem[s_addr];
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fillImage(input int n, input logic [PIX_W-1:0] v);
    for (int i = 0; i < n; i++) mem[i] = v;
  endtask

  // Raster-order model: sum of all pixels, first PRE_S->START_CODE and
  // first PRE_E->END_CODE pair, coordinates from the linear index.
  task automatic computeModel(input int w, input int h);
    int n;
    n = w * h;
    exp_sum = 0;
    exp_sf = 1'b0; exp_ef = 1'b0;
    exp_sx = 0; exp_sy = 0; exp_ex = 0; exp_ey = 0;
    for (int i = 0; i < n; i++) begin
      exp_sum += int'(mem[i]);
      if (i > 0) begin
        if (!exp_sf && mem[i-1] == PRE_S && mem[i] == START_CODE) begin
          exp_sf = 1'b1; exp_sx = i % w; exp_sy = i / w;
        end
        if (!exp_ef && mem[i-1] == PRE_E && mem[i] == END_CODE) begin
          exp_ef = 1'b1; exp_ex = i % w; exp_ey = i / w;
        end
      end
    end
  endtask

  // k = edges since the accepting edge. Request issued for k < n, done at
  // k = n+2, busy through the done cycle, results final from done onward.
  task automatic checkCycle(input string tag, input int k, input int n,
                            input logic busy, input logic done, input logic en,
                            input logic [ADDR_W-1:0] addr, input logic [SUM_W-1:0] sum,
                            input logic sf, input logic [11:0] sx, input logic [11:0] sy,
                            input logic ef, input logic [11:0] ex, input logic [11:0] ey);
    checkOutput({tag, ".busy"}, busy, (k <= n + 2));
    checkOutput({tag, ".done"}, done, (k == n + 2));
    checkOutput({tag, ".sram_en"}, en, (k < n));
    if (k < n) checkOutput({tag, ".sram_addr"}, addr, k);
    if (done) done_k = k;
    if (k >= n + 2) begin
      checkOutput({tag, ".sum"}, sum, exp_sum);
      checkOutput({tag, ".start_found"}, sf, exp_sf);
      checkOutput({tag, ".start_x"}, sx, exp_sx);
      checkOutput({tag, ".start_y"}, sy, exp_sy);
      checkOutput({tag, ".end_found"}, ef, exp_ef);
      checkOutput({tag, ".end_x"}, ex, exp_ex);
      checkOutput({tag, ".end_y"}, ey, exp_ey);
    end
  endtask

  always @(negedge clk) begin
    if (mon_big && (edge_cnt - t0) >= 0)
      checkCycle("big", edge_cnt - t0, NB, b_busy, b_done, b_en, b_addr, b_sum,
                 b_sf, b_sx, b_sy, b_ef, b_ex, b_ey);
    if (mon_small && (edge_cnt - t0) >= 0)
      checkCycle("small", edge_cnt - t0, NS, s_busy, s_done, s_en, s_addr, s_sum,
                 s_sf, s_sx, s_sy, s_ef, s_ex, s_ey);
  end

  // Issues one start pulse, optionally a second pulse at k = extra_k, and
  // keeps the per-cycle monitor running for stop_k cycles.
  task automatic applyStimulus(input bit big, input int extra_k, input int stop_k);
    @(negedge clk);
    t0 = edge_cnt + 1;
    done_k = -1;
    if (big) begin start_big = 1'b1; mon_big = 1'b1; end
    else begin start_small = 1'b1; mon_small = 1'b1; end
    for (int i = 0; i < stop_k; i++) begin
      @(negedge clk);
      if (big) start_big = (i == extra_k);
      else start_small = (i == extra_k);
    end
    start_big = 1'b0;
    start_small = 1'b0;
    mon_big = 1'b0;
    mon_small = 1'b0;
  endtask

  task automatic checkSmallResult(input string tag, input int s, input bit sf, input int sx,
                                  input int sy, input bit ef, input int ex, input int ey);
    checkOutput({tag, ".latency"}, done_k, NS + 2);
    checkOutput({tag, ".sum"}, s_sum, s);
    checkOutput({tag, ".start_found"}, s_sf, sf);
    checkOutput({tag, ".start_x"}, s_sx, sx);
    checkOutput({tag, ".start_y"}, s_sy, sy);
    checkOutput({tag, ".end_found"}, s_ef, ef);
    checkOutput({tag, ".end_x"}, s_ex, ex);
    checkOutput({tag, ".end_y"}, s_ey, ey);
  endtask

  task automatic loadImageC();
    fillImage(NS, 3'd7);
    mem[999] = 3'd4; mem[1000] = 3'd0;
    mem[1999] = 3'd4; mem[2000] = 3'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    start_big = 1'b0;
    start_small = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", s_busy, 0);
    checkOutput("reset.done", s_done, 0);
    checkOutput("reset.sram_en", s_en, 0);
    checkOutput("reset.sram_addr", s_addr, 0);
    checkOutput("reset.sum", s_sum, 0);
    checkOutput("reset.big_busy", b_busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-size blank image: done exactly 76802 edges after acceptance.
    fillImage(NB, 3'd0);
    computeModel(IMG_W, IMG_H);
    applyStimulus(1'b1, -1, NB + 6);
    checkOutput("blank.latency", done_k, 76802);
    checkOutput("blank.sum", b_sum, 0);
    checkOutput("blank.start_found", b_sf, 0);
    checkOutput("blank.end_found", b_ef, 0);

    // Start at pixel 6, end on the very last pixel (319,6).
    fillImage(NS, 3'd7);
    mem[5] = 3'd4; mem[6] = 3'd0;
    mem[NS-2] = 3'd0; mem[NS-1] = 3'd4;
    computeModel(SW, SH);
    applyStimulus(1'b0, -1, NS + 6);
    checkSmallResult("first_start", 15660, 1, 6, 0, 1, 319, 6);

    // Row-crossing end at (0,1); pixel 0 = START_CODE after a scan that
    // ended on PRE_S must not count as a start.
    fillImage(NS, 3'd7);
    mem[0] = 3'd0; mem[319] = 3'd0; mem[320] = 3'd4;
    computeModel(SW, SH);
    applyStimulus(1'b0, -1, NS + 6);
    checkSmallResult("row_cross_end", 15663, 0, 0, 0, 1, 0, 1);

    // Two start transitions, first wins; extra start while busy is ignored.
    loadImageC();
    computeModel(SW, SH);
    applyStimulus(1'b0, 100, NS + 6);
    checkSmallResult("two_starts", 15660, 1, 40, 3, 0, 0, 0);

    // Reset mid-scan: outputs clear without a clock edge, no done follows.
    fillImage(NS, 3'd7);
    mem[5] = 3'd4; mem[6] = 3'd0;
    computeModel(SW, SH);
    applyStimulus(1'b0, -1, 500);
    reset_n = 1'b0;
    #1;
    checkOutput("abort.busy", s_busy, 0);
    checkOutput("abort.sram_en", s_en, 0);
    checkOutput("abort.sram_addr", s_addr, 0);
    checkOutput("abort.sum", s_sum, 0);
    checkOutput("abort.start_found", s_sf, 0);
    checkOutput("abort.start_x", s_sx, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("abort.no_done", s_done, 0);
      checkOutput("abort.idle_busy", s_busy, 0);
    end

    // Fresh single request after the abort matches the two_starts result.
    loadImageC();
    computeModel(SW, SH);
    applyStimulus(1'b0, -1, NS + 6);
    checkSmallResult("after_abort", 15660, 1, 40, 3, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
